fpu_mul_scheduler: RTL and testbench

- Shares one single-precision `multiplier` instance between NUM_REQ independent requesters, such as rasteriser setup or texture address units.
- Grants are round-robin; one operation is in flight at a time.
- Latches the winner's operands, issues a one-cycle exec strobe and waits for the done strobe.
- Returns the result with a one-hot completion pulse to the winning requester.
- Sits between the requesters and the multiplier; the multiplier's own ports are wired directly to the `mul_*` ports.

---
 rtl/fpu_pkg.sv | 15 +
 rtl/fpu_mul_scheduler_rr_arbiter.sv | 28 ++
 rtl/fpu_mul_scheduler.sv | 88 ++++++++
 tb/tb_fpu_mul_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision FPU scheduler blocks.
package fpu_pkg;

  typedef logic [31:0] float32_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

  localparam float32_t FP_ONE  = 32'h3F80_0000;
  localparam float32_t FP_QNAN = 32'hFFC0_0000;

endpackage

// File: rtl/fpu_mul_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  int k;

  // Scan from the farthest offset down so the offset closest to ptr wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    k           = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (req[k]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fpu_mul_scheduler.sv
// Shares one single-precision multiplier between NUM_REQ requesters, one
// operation in flight, round-robin grants, one-hot completion pulses.
module fpu_mul_scheduler
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*32-1:0] a_value_i,
  input  logic [NUM_REQ*32-1:0] b_value_i,
  output logic [NUM_REQ-1:0]    done_o,
  output logic [31:0]           z_value_o,
  output logic                  busy_o,
  output logic [IDX_W-1:0]      grant_idx_o,
  output logic [31:0]           mul_a_value_o,
  output logic [31:0]           mul_b_value_o,
  output logic                  mul_exec_strobe_o,
  input  logic [31:0]           mul_z_value_i,
  input  logic                  mul_done_strobe_i
);

  sched_state_t     state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic [IDX_W-1:0] next_ptr;
  float32_t         sel_a;
  float32_t         sel_b;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req        (req_i),
    .ptr        (ptr),
    .grant_valid(arb_valid),
    .grant_idx  (arb_idx)
  );

  assign sel_a    = a_value_i[32*int'(arb_idx) +: 32];
  assign sel_b    = b_value_i[32*int'(arb_idx) +: 32];
  assign next_ptr = (grant_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_o + 1'b1;

  // Operands stay latched through WAIT: the multiplier samples them a cycle after exec.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state             <= IDLE;
      ptr               <= '0;
      done_o            <= '0;
      z_value_o         <= '0;
      busy_o            <= 1'b0;
      grant_idx_o       <= '0;
      mul_a_value_o     <= '0;
      mul_b_value_o     <= '0;
      mul_exec_strobe_o <= 1'b0;
    end else begin
      done_o            <= '0;
      mul_exec_strobe_o <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            mul_a_value_o     <= sel_a;
            mul_b_value_o     <= sel_b;
            grant_idx_o       <= arb_idx;
            busy_o            <= 1'b1;
            mul_exec_strobe_o <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mul_done_strobe_i) begin
            z_value_o <= mul_z_value_i;
            done_o    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_o;
            ptr       <= next_ptr;
            busy_o    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mul_scheduler.sv
// Directed bench for fpu_mul_scheduler with a small lookup-table multiplier model.
module tb_fpu_mul_scheduler;
  import fpu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int LIMIT   = 60;

  logic                  clk = 1'b0;
  logic                  reset_i;
  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ*32-1:0] a_value_i;
  logic [NUM_REQ*32-1:0] b_value_i;
  logic [NUM_REQ-1:0]    done_o;
  logic [31:0]           z_value_o;
  logic                  busy_o;
  logic [IDX_W-1:0]      grant_idx_o;
  logic [31:0]           mul_a_value_o;
  logic [31:0]           mul_b_value_o;
  logic                  mul_exec_strobe_o;
  logic [31:0]           mul_z_value_i;
  logic                  mul_done_strobe_i;

  logic                  model_done;
  logic                  stray_done;
  logic [1:0]            mcnt;
  logic [31:0]           ma, mb;
  int                    exec_cnt;
  int                    n_checks = 0;
  int                    n_fail   = 0;

  always #5 clk = ~clk;

  fpu_mul_scheduler #(.NUM_REQ(NUM_REQ)) dut (
    .clk              (clk),
    .reset_i          (reset_i),
    .req_i            (req_i),
    .a_value_i        (a_value_i),
    .b_value_i        (b_value_i),
    .done_o           (done_o),
    .z_value_o        (z_value_o),
    .busy_o           (busy_o),
    .grant_idx_o      (grant_idx_o),
    .mul_a_value_o    (mul_a_value_o),
    .mul_b_value_o    (mul_b_value_o),
    .mul_exec_strobe_o(mul_exec_strobe_o),
    .mul_z_value_i    (mul_z_value_i),
    .mul_done_strobe_i(mul_done_strobe_i)
  );

  // Hand-computed products for every operand pair the bench uses.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: fmul = 32'h40C00000;
      {32'h3F800000, 32'h3F800000}: fmul = 32'h3F800000;
      {32'h40000000, 32'h40000000}: fmul = 32'h40800000;
      {32'h40400000, 32'h40400000}: fmul = 32'h41100000;
      {32'h40800000, 32'h40800000}: fmul = 32'h41800000;
      {32'h3FC00000, 32'h3FC00000}: fmul = 32'h40100000;
      {32'h40A00000, 32'h3FC00000}: fmul = 32'h40F00000;
      {32'h7F800000, 32'h00000000}: fmul = 32'hFFC00000;
      default:                      fmul = 32'hBADBAD00;
    endcase
  endfunction

  // Multiplier model: samples operands one cycle after exec, done two cycles later.
  always @(posedge clk) begin
    if (reset_i) begin
      mcnt       <= 2'd0;
      model_done <= 1'b0;
      exec_cnt   <= 0;
    end else begin
      model_done <= 1'b0;
      if (mul_exec_strobe_o) begin
        exec_cnt <= exec_cnt + 1;
        mcnt     <= 2'd1;
      end else if (mcnt == 2'd1) begin
        ma   <= mul_a_value_o;
        mb   <= mul_b_value_o;
        mcnt <= 2'd2;
      end else if (mcnt == 2'd2) begin
        mcnt <= 2'd3;
      end else if (mcnt == 2'd3) begin
        model_done    <= 1'b1;
        mul_z_value_i <= fmul(ma, mb);
        mcnt          <= 2'd0;
      end
    end
  end

  assign mul_done_strobe_i = model_done | stray_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    req_i   = '0;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b);
    a_value_i[k*32 +: 32] = a;
    b_value_i[k*32 +: 32] = b;
  endtask

  task automatic wait_done(output logic [3:0] d, output logic [31:0] z);
    d = '0;
    z = '0;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      if (done_o != '0) begin
        d = done_o;
        z = z_value_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({done_o, z_value_o, busy_o, grant_idx_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b z=%h busy=%b idx=%0d, want all 0",
               done_o, z_value_o, busy_o, grant_idx_o);
    end
    n_checks++;
    if ({mul_a_value_o, mul_b_value_o, mul_exec_strobe_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mul_ports: got a=%h b=%h exec=%b, want 0",
               mul_a_value_o, mul_b_value_o, mul_exec_strobe_o);
    end
  endtask

  task automatic test_single();
    logic [3:0] d;
    logic [31:0] z;
    int e0;
    do_reset();
    e0 = exec_cnt;
    set_ops(0, 32'h40000000, 32'h40400000);
    req_i = 4'b0001;
    tick();
    n_checks++;
    if ({mul_exec_strobe_o, busy_o, grant_idx_o} !== {1'b1, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL single_issue: got exec=%b busy=%b idx=%0d, want 1 1 0",
               mul_exec_strobe_o, busy_o, grant_idx_o);
    end
    tick();
    n_checks++;
    if (mul_exec_strobe_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_exec_width: got exec=%b, want 0", mul_exec_strobe_o);
    end
    wait_done(d, z);
    req_i = '0;
    n_checks++;
    if (d !== 4'b0001 || z !== 32'h40C00000) begin
      n_fail++;
      $display("FAIL single_result: got done=%b z=%h, want 0001 40c00000", d, z);
    end
    tick();
    n_checks++;
    if (exec_cnt - e0 !== 1) begin
      n_fail++;
      $display("FAIL single_exec_count: got %0d, want 1", exec_cnt - e0);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  d;
    logic [31:0] z;
    logic [3:0]  exp_d [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] exp_z [5] = '{32'h3F800000, 32'h40800000, 32'h41100000,
                               32'h41800000, 32'h3F800000};
    do_reset();
    set_ops(0, 32'h3F800000, 32'h3F800000);
    set_ops(1, 32'h40000000, 32'h40000000);
    set_ops(2, 32'h40400000, 32'h40400000);
    set_ops(3, 32'h40800000, 32'h40800000);
    req_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done(d, z);
      if (n == 4) req_i = '0;
      n_checks++;
      if (d !== exp_d[n] || z !== exp_z[n]) begin
        n_fail++;
        $display("FAIL rr_op%0d: got done=%b z=%h, want %b %h", n, d, z, exp_d[n], exp_z[n]);
      end
    end
    tick();
  endtask

  task automatic test_pointer_wrap();
    logic [3:0]  d;
    logic [31:0] z;
    do_reset();
    set_ops(0, 32'h3F800000, 32'h3F800000);
    set_ops(3, 32'h40800000, 32'h40800000);
    req_i = 4'b1000;
    tick();
    req_i = 4'b1001;
    wait_done(d, z);
    n_checks++;
    if (d !== 4'b1000 || z !== 32'h41800000) begin
      n_fail++;
      $display("FAIL wrap_first: got done=%b z=%h, want 1000 41800000", d, z);
    end
    wait_done(d, z);
    n_checks++;
    if (d !== 4'b0001 || z !== 32'h3F800000) begin
      n_fail++;
      $display("FAIL wrap_second: got done=%b z=%h, want 0001 3f800000", d, z);
    end
    wait_done(d, z);
    req_i = '0;
    n_checks++;
    if (d !== 4'b1000 || z !== 32'h41800000) begin
      n_fail++;
      $display("FAIL wrap_third: got done=%b z=%h, want 1000 41800000", d, z);
    end
    tick();
  endtask

  task automatic test_operand_stability();
    logic [3:0]  d;
    logic [31:0] z;
    do_reset();
    set_ops(1, 32'h3FC00000, 32'h3FC00000);
    req_i = 4'b0010;
    tick();
    tick();
    set_ops(1, 32'h40A00000, 32'h3FC00000);
    tick();
    n_checks++;
    if (mul_a_value_o !== 32'h3FC00000) begin
      n_fail++;
      $display("FAIL stable_mul_a: got %h, want 3fc00000", mul_a_value_o);
    end
    wait_done(d, z);
    req_i = '0;
    n_checks++;
    if (d !== 4'b0010 || z !== 32'h40100000) begin
      n_fail++;
      $display("FAIL stable_result: got done=%b z=%h, want 0010 40100000", d, z);
    end
    tick();
  endtask

  task automatic test_special();
    logic [3:0]  d;
    logic [31:0] z;
    do_reset();
    set_ops(2, 32'h7F800000, 32'h00000000);
    req_i = 4'b0100;
    wait_done(d, z);
    req_i = '0;
    n_checks++;
    if (d !== 4'b0100 || z !== FP_QNAN) begin
      n_fail++;
      $display("FAIL special_result: got done=%b z=%h, want 0100 ffc00000", d, z);
    end
    tick();
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 4'b0000 || z_value_o !== FP_QNAN) begin
      n_fail++;
      $display("FAIL special_after: got busy=%b done=%b z=%h, want 0 0000 ffc00000",
               busy_o, done_o, z_value_o);
    end
  endtask

  task automatic test_stray_done();
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    n_checks++;
    if (done_o !== 4'b0000 || busy_o !== 1'b0 || z_value_o !== FP_QNAN) begin
      n_fail++;
      $display("FAIL stray_done: got done=%b busy=%b z=%h, want 0000 0 ffc00000",
               done_o, busy_o, z_value_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0]  d;
    logic [31:0] z;
    int seen;
    do_reset();
    set_ops(1, 32'h3F800000, 32'h3F800000);
    req_i = 4'b0010;
    wait_done(d, z);
    req_i = '0;
    tick();
    set_ops(0, 32'h3FC00000, 32'h3FC00000);
    set_ops(3, 32'h40800000, 32'h40800000);
    req_i = 4'b1000;
    tick();
    tick();
    tick();
    reset_i = 1'b1;
    req_i   = '0;
    tick();
    reset_i = 1'b0;
    n_checks++;
    if ({done_o, z_value_o, busy_o, grant_idx_o, mul_a_value_o, mul_b_value_o,
         mul_exec_strobe_o} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got done=%b z=%h busy=%b idx=%0d a=%h b=%h exec=%b, want 0",
               done_o, z_value_o, busy_o, grant_idx_o, mul_a_value_o, mul_b_value_o,
               mul_exec_strobe_o);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_o != '0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d pulses, want 0", seen);
    end
    set_ops(3, 32'h3FC00000, 32'h3FC00000);
    req_i = 4'b1001;
    wait_done(d, z);
    req_i = 4'b1000;
    n_checks++;
    if (d !== 4'b0001 || z !== 32'h40100000) begin
      n_fail++;
      $display("FAIL abort_recover: got done=%b z=%h, want 0001 40100000", d, z);
    end
    wait_done(d, z);
    req_i = '0;
    n_checks++;
    if (d !== 4'b1000 || z !== 32'h40100000) begin
      n_fail++;
      $display("FAIL abort_recover_next: got done=%b z=%h, want 1000 40100000", d, z);
    end
    tick();
  endtask

  initial begin
    reset_i    = 1'b1;
    req_i      = '0;
    a_value_i  = '0;
    b_value_i  = '0;
    stray_done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_operand_stability();
    test_special();
    test_stray_done();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
